// File: rtl/booth_seq_mul256_if.sv
// Handshake and multiplier-side bus for booth_seq_mul256.
// The slave modport is the controller. The master modport is its environment: the operand source, the result sink and the multiplier.
interface booth_seq_mul256_if #(
  parameter int A_LEN   = 256,
  parameter int B_LEN   = 256,
  parameter int M_B_LEN = 64
);
  localparam int M_P_LEN = A_LEN + M_B_LEN;
  localparam int P_LEN   = A_LEN + B_LEN;

  logic               in_valid;
  logic               in_ready;
  logic [A_LEN-1:0]   in_a;
  logic [B_LEN-1:0]   in_b;
  logic [A_LEN-1:0]   mul_a;
  logic [M_B_LEN-1:0] mul_b;
  logic [M_P_LEN-1:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic [P_LEN-1:0]   out_p;
  logic               busy;

  modport slave (
    input  in_valid, in_a, in_b, mul_p, out_ready,
    output in_ready, mul_a, mul_b, out_valid, out_p, busy
  );

  modport master (
    output in_valid, in_a, in_b, mul_p, out_ready,
    input  in_ready, mul_a, mul_b, out_valid, out_p, busy
  );
endinterface

// File: rtl/booth_seq_mul256.sv
// Sequential 256x256 signed multiply built on an external combinational 256x64 multiplier.
// Each of five passes feeds one chunk of b to the multiplier and shift-accumulates the 320-bit product.
module booth_seq_mul256 #(
  parameter int A_LEN   = 256,
  parameter int B_LEN   = 256,
  parameter int M_B_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  booth_seq_mul256_if.slave bus
);
  localparam int CHUNK   = M_B_LEN - 1;
  localparam int NPASS   = (B_LEN + CHUNK - 1) / CHUNK;
  localparam int P_LEN   = A_LEN + B_LEN;
  localparam int M_P_LEN = A_LEN + M_B_LEN;
  localparam int LAST_W  = B_LEN - CHUNK * (NPASS - 1);
  localparam int CNT_W   = $clog2(NPASS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NPASS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic signed [A_LEN-1:0]  a_reg;
  logic [B_LEN-1:0]         b_reg;
  logic signed [P_LEN-1:0]  acc;
  logic [M_B_LEN-1:0]       chunk;
  logic signed [P_LEN-1:0]  addend;

  function automatic logic signed [P_LEN-1:0] sext_p(input logic [M_P_LEN-1:0] p);
    return {{(P_LEN - M_P_LEN){p[M_P_LEN-1]}}, p};
  endfunction

  // Lower chunks are zero-extended so they act as unsigned digits; only the top chunk carries b's sign.
  always_comb begin
    chunk = '0;
    if (state == RUN) begin
      if (cnt == LAST_CNT) begin
        chunk = {{(M_B_LEN - LAST_W){b_reg[B_LEN-1]}}, b_reg[B_LEN-1 -: LAST_W]};
      end else begin
        for (int k = 0; k < NPASS - 1; k++) begin
          if (cnt == CNT_W'(k)) chunk = {1'b0, b_reg[CHUNK*k +: CHUNK]};
        end
      end
    end
  end

  assign addend        = sext_p(bus.mul_p) <<< (CHUNK * int'(cnt));
  assign bus.mul_a     = a_reg;
  assign bus.mul_b     = chunk;
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_p     = acc;

  // Controller and accumulator; reset clears data too so no stale operand leaks onto mul_a/out_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + addend;
          if (cnt == LAST_CNT) state <= DONE;
          else                 cnt   <= cnt + 1'b1;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mul256.sv
// Directed bench for booth_seq_mul256 with a behavioural 256x64 signed multiplier attached.
module tb_booth_seq_mul256;
  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  booth_seq_mul256_if #(.A_LEN(256), .B_LEN(256), .M_B_LEN(64)) bus ();

  booth_seq_mul256 #(.A_LEN(256), .B_LEN(256), .M_B_LEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Attached multiplier: signed 256 x signed 64, exact in 320 bits.
  logic signed [319:0] ma_ext;
  logic signed [319:0] mb_ext;
  assign ma_ext    = {{64{bus.mul_a[255]}}, bus.mul_a};
  assign mb_ext    = {{256{bus.mul_b[63]}}, bus.mul_b};
  assign bus.mul_p = ma_ext * mb_ext;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                        input logic [511:0] exp);
    int n;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    chk({tag, ".mul_a"}, bus.mul_a, a);
    chk({tag, ".mul_b_pass0"}, bus.mul_b, {1'b0, b[62:0]});
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      chk({tag, ".in_ready_run"}, bus.in_ready, 0);
      tick;
      n++;
    end
    chk({tag, ".latency"}, n, 5);
    chk({tag, ".out_p"}, bus.out_p, exp);
    chk({tag, ".in_ready_done"}, bus.in_ready, 0);
    if (bus.out_ready) begin
      tick;
      chk({tag, ".out_valid_after"}, bus.out_valid, 0);
      chk({tag, ".in_ready_after"}, bus.in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] neg_min;
    logic [255:0] pos_max;
    logic [511:0] e;
    nchk = 0;
    nerr = 0;
    clk  = 1'b0;
    rst  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    neg_min = 256'd1 << 255;
    pos_max = neg_min - 256'd1;

    #1;
    chk("rst.in_ready", bus.in_ready, 1);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.out_p", bus.out_p, 0);
    chk("rst.mul_a", bus.mul_a, 0);
    chk("rst.mul_b", bus.mul_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("t1_3x5", 256'd3, 256'd5, 512'd15);
    run_op("t2_m1x1", '1, 256'd1, '1);
    run_op("t3_minxmin", neg_min, neg_min, 512'd1 << 510);
    run_op("t4_b63", 256'd1, 256'd1 << 63, 512'd1 << 63);
    run_op("t4_b252", 256'd1, 256'd1 << 252, 512'd1 << 252);
    e = (512'd1 << 510) - (512'd1 << 256) + 512'd1;
    run_op("t_maxxmax", pos_max, pos_max, e);
    e = (512'd1 << 255) - (512'd1 << 510);
    run_op("t_maxxmin", pos_max, neg_min, e);

    // Backpressure: hold the result ten cycles, with a stray in_valid pulse.
    bus.out_ready = 1'b0;
    run_op("t5_bp", 256'd11, 256'd13, 512'd143);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 3);
      bus.in_a     = 256'd2;
      bus.in_b     = 256'd2;
      tick;
      chk("t5.hold_valid", bus.out_valid, 1);
      chk("t5.hold_p", bus.out_p, 512'd143);
      chk("t5.hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    chk("t5.after_valid", bus.out_valid, 0);
    chk("t5.after_in_ready", bus.in_ready, 1);
    tick;
    chk("t5.idle_busy", bus.busy, 0);

    // Reset mid-operation at cnt=2.
    bus.in_a     = 256'd9;
    bus.in_b     = 256'd9;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    tick;
    chk("t6.busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("t6.out_valid", bus.out_valid, 0);
    chk("t6.busy", bus.busy, 0);
    chk("t6.in_ready", bus.in_ready, 1);
    chk("t6.out_p", bus.out_p, 0);
    chk("t6.mul_a", bus.mul_a, 0);
    chk("t6.mul_b", bus.mul_b, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t6.no_out_valid", bus.out_valid, 0);
    end
    run_op("t6_7xm6", 256'd7, -256'd6, -512'd42);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
